// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port between CPU and DMA
//
// Purpose:
//    Owns the single data memory port and serialises CPU and DMA accesses with a
//    req/ack handshake. Ties are broken round-robin. A CPU that asks for bus
//    retention (cpu_lock) keeps the port for a bounded number of further grants
//    while DMA waits, so multi-byte fetches stay back-to-back without starving DMA.
//
// Ports:
//    clk, reset                  clock (rising edge), asynchronous active-low reset
//    cpu_req/we/lock/addr/wdata  CPU request side; req held until cpu_ack
//    cpu_ack, cpu_rdata          CPU one-cycle completion pulse and read data
//    dma_req/we/addr/wdata       DMA request side (no lock)
//    dma_ack, dma_rdata          DMA one-cycle completion pulse and read data
//    mem_en/we/addr/wdata        memory strobe, write enable, address, write data
//    mem_rdata                   memory read data
//    busy                        high whenever the arbiter is not idle

module mem_bus_arbiter #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int MEM_LATENCY = 2,
   parameter int MAX_LOCK    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_lock,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int LCK_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
   localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(MAX_LOCK);

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [CNT_W-1:0]  r_cnt;
   logic              r_owner;
   logic              r_last_gnt;
   logic              r_lock_flag;
   logic [LCK_W-1:0]  r_lock_cnt;
   logic              r_gnt_locked;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dma_rdata;

   logic              w_lock_hold;
   logic              w_any_req;
   logic              w_gnt;

   // Grant selection. The lock hold wins outright; otherwise a lone requester
   // wins, and a tie goes to whoever was not served last.
   always_comb begin
      w_lock_hold = (r_last_gnt == OWN_CPU) && r_lock_flag &&
                    (r_lock_cnt < LOCK_MAX) && cpu_req;
      w_any_req   = cpu_req || dma_req;
      w_gnt       = OWN_CPU;
      if (w_lock_hold) begin
         w_gnt = OWN_CPU;
      end else if (cpu_req && !dma_req) begin
         w_gnt = OWN_CPU;
      end else if (dma_req && !cpu_req) begin
         w_gnt = OWN_DMA;
      end else if (cpu_req && dma_req) begin
         w_gnt = ~r_last_gnt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (r_cnt == CNT_LAST) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt        <= '0;
         r_owner      <= OWN_CPU;
         r_last_gnt   <= OWN_DMA;
         r_lock_flag  <= 1'b0;
         r_lock_cnt   <= '0;
         r_gnt_locked <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_cpu_rdata  <= '0;
         r_dma_rdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Request fields are captured here, so the requester may change
               // its address/data inputs during the access without effect.
               if (w_any_req) begin
                  r_owner      <= w_gnt;
                  r_gnt_locked <= w_lock_hold;
                  r_cnt        <= '0;
                  if (w_gnt == OWN_DMA) begin
                     r_mem_we    <= dma_we;
                     r_mem_addr  <= dma_addr;
                     r_mem_wdata <= dma_wdata;
                  end else begin
                     r_mem_we    <= cpu_we;
                     r_mem_addr  <= cpu_addr;
                     r_mem_wdata <= cpu_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // Read data is valid only in the final strobe cycle; writes capture
               // it too and the requester ignores it.
               if (r_cnt == CNT_LAST) begin
                  if (r_owner == OWN_DMA) begin
                     r_dma_rdata <= mem_rdata;
                  end else begin
                     r_cpu_rdata <= mem_rdata;
                  end
               end
            end
            ST_DONE: begin
               r_last_gnt  <= r_owner;
               r_lock_flag <= (r_owner == OWN_CPU) && cpu_lock;
               // Only locked grants that actually held DMA off count toward the
               // bound; anything else restarts the budget.
               if (r_gnt_locked && dma_req) begin
                  r_lock_cnt <= r_lock_cnt + LCK_W'(1);
               end else begin
                  r_lock_cnt <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_en    = (r_state == ST_ACCESS);
   assign mem_we    = (r_state == ST_ACCESS) && r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_ack   = (r_state == ST_DONE) && (r_owner == OWN_CPU);
   assign dma_ack   = (r_state == ST_DONE) && (r_owner == OWN_DMA);
   assign cpu_rdata = r_cpu_rdata;
   assign dma_rdata = r_dma_rdata;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

   localparam int ML = 2;

   logic       clk;
   logic       reset;
   logic       cpu_req;
   logic       cpu_we;
   logic       cpu_lock;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_ack;
   logic [7:0] cpu_rdata;
   logic       dma_req;
   logic       dma_we;
   logic [7:0] dma_addr;
   logic [7:0] dma_wdata;
   logic       dma_ack;
   logic [7:0] dma_rdata;
   logic       mem_en;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   mem_bus_arbiter #(
      .ADDR_W      (8),
      .DATA_W      (8),
      .MEM_LATENCY (ML),
      .MAX_LOCK    (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_lock  (cpu_lock),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_ack   (dma_ack),
      .dma_rdata (dma_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       c_req;
      logic       c_we;
      logic [7:0] c_addr;
      logic [7:0] c_wdata;
      logic       d_req;
      logic       d_we;
      logic [7:0] d_addr;
      logic [7:0] d_wdata;
      logic [7:0] mem_val;
      logic       e_dma;
      logic       e_we;
      logic [7:0] e_addr;
      logic [7:0] e_wdata;
      logic [7:0] e_rdata;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_lock  = 1'b0;
      cpu_addr  = 8'h00;
      cpu_wdata = 8'h00;
      dma_req   = 1'b0;
      dma_we    = 1'b0;
      dma_addr  = 8'h00;
      dma_wdata = 8'h00;
      mem_rdata = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Waits for the next ack; who: 0 CPU, 1 DMA, 2 both, -1 none within budget.
   task automatic get_grant(output int who, output int cycles);
      who    = -1;
      cycles = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (cpu_ack || dma_ack) begin
            who    = (cpu_ack && dma_ack) ? 2 : (dma_ack ? 1 : 0);
            cycles = i;
            break;
         end
      end
   endtask

   // Entered at a negedge with the arbiter idle; returns at a negedge, idle again.
   task automatic run_vec(input int idx, input vec_t v);
      cpu_req   = v.c_req;
      cpu_we    = v.c_we;
      cpu_addr  = v.c_addr;
      cpu_wdata = v.c_wdata;
      dma_req   = v.d_req;
      dma_we    = v.d_we;
      dma_addr  = v.d_addr;
      dma_wdata = v.d_wdata;
      mem_rdata = v.mem_val;
      for (int k = 0; k < ML; k++) begin
         @(negedge clk);
         chk($sformatf("v%0d access%0d en/we/addr/wdata/acks", idx, k),
             32'({mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dma_ack}),
             32'({1'b1, v.e_we, v.e_addr, v.e_wdata, 2'b00}));
      end
      @(negedge clk);
      chk($sformatf("v%0d done cpu_ack/dma_ack/en/we/busy", idx),
          32'({cpu_ack, dma_ack, mem_en, mem_we, busy}),
          32'({~v.e_dma, v.e_dma, 1'b0, 1'b0, 1'b1}));
      if (!v.e_we) begin
         chk($sformatf("v%0d rdata", idx),
             32'(v.e_dma ? dma_rdata : cpu_rdata), 32'(v.e_rdata));
      end
      cpu_req = 1'b0;
      dma_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d idle busy", idx), 32'(busy), 32'(0));
   endtask

   int who;
   int cyc;
   int exp_seq [7];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5,
                  1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
      vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h80, 8'h3C, 8'hEE,
                  1'b1, 1'b1, 8'h80, 8'h3C, 8'h00};
      vecs[2] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 8'h5A,
                  1'b0, 1'b0, 8'h20, 8'h00, 8'h5A};
      vecs[3] = '{1'b1, 1'b1, 8'h41, 8'h11, 1'b1, 1'b0, 8'h42, 8'h00, 8'h77,
                  1'b1, 1'b0, 8'h42, 8'h00, 8'h77};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h3E,
                  1'b1, 1'b0, 8'hFF, 8'h00, 8'h3E};
      vecs[5] = '{1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h01, 8'h01, 8'h99,
                  1'b0, 1'b1, 8'h00, 8'hFF, 8'h00};
      vecs[6] = '{1'b1, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3,
                  1'b0, 1'b0, 8'h7F, 8'h00, 8'hC3};
      exp_seq = '{0, 0, 0, 0, 0, 1, 0};

      // Reset values
      clear_inputs();
      reset = 1'b0;
      #12;
      chk("reset outputs",
          32'({cpu_ack, dma_ack, mem_en, mem_we, busy, mem_addr, mem_wdata}), 32'(0));
      chk("reset rdata", 32'({cpu_rdata, dma_rdata}), 32'(0));
      @(negedge clk);
      reset = 1'b1;

      // Simultaneous requests straight after reset: CPU, then DMA, then CPU
      cpu_req = 1'b1;
      dma_req = 1'b1;
      get_grant(who, cyc);
      chk("tie1 owner", 32'(who), 32'(0));
      chk("tie1 latency", 32'(cyc), 32'(ML + 1));
      get_grant(who, cyc);
      chk("tie2 owner", 32'(who), 32'(1));
      chk("tie2 spacing", 32'(cyc), 32'(ML + 2));
      get_grant(who, cyc);
      chk("tie3 owner", 32'(who), 32'(0));
      chk("tie3 spacing", 32'(cyc), 32'(ML + 2));
      cpu_req = 1'b0;
      dma_req = 1'b0;
      @(negedge clk);

      // Table of single accesses and ties, starting from last grant = DMA
      do_reset();
      for (int i = 0; i < 7; i++) begin
         run_vec(i, vecs[i]);
      end

      // Bounded CPU lock with DMA held pending
      do_reset();
      cpu_req  = 1'b1;
      cpu_lock = 1'b1;
      dma_req  = 1'b1;
      for (int g = 0; g < 7; g++) begin
         get_grant(who, cyc);
         chk($sformatf("lock grant%0d owner", g), 32'(who), 32'(exp_seq[g]));
      end
      cpu_req  = 1'b0;
      cpu_lock = 1'b0;
      dma_req  = 1'b0;
      @(negedge clk);

      // Reset during ACCESS drops the access
      do_reset();
      cpu_req   = 1'b1;
      cpu_addr  = 8'h55;
      mem_rdata = 8'h96;
      @(negedge clk);
      chk("midreset pre busy/en", 32'({busy, mem_en}), 32'(2'b11));
      reset = 1'b0;
      #1;
      chk("midreset outputs zero",
          32'({busy, mem_en, mem_we, cpu_ack, dma_ack, mem_addr}), 32'(0));
      cpu_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("midreset hold%0d", k),
             32'({busy, mem_en, cpu_ack, dma_ack}), 32'(0));
      end
      reset   = 1'b1;
      cpu_req = 1'b1;
      get_grant(who, cyc);
      chk("reissue owner", 32'(who), 32'(0));
      chk("reissue latency", 32'(cyc), 32'(ML + 1));
      chk("reissue rdata", 32'(cpu_rdata), 32'(8'h96));
      cpu_req = 1'b0;
      @(negedge clk);

      // Request dropped mid-access still completes; address changes ignored
      cpu_req   = 1'b1;
      cpu_addr  = 8'h21;
      mem_rdata = 8'h4B;
      @(negedge clk);
      cpu_req  = 1'b0;
      cpu_addr = 8'hEE;
      @(negedge clk);
      chk("drop latched addr/en", 32'({mem_en, mem_addr}), 32'({1'b1, 8'h21}));
      get_grant(who, cyc);
      chk("drop ack owner", 32'(who), 32'(0));
      chk("drop ack timing", 32'(cyc), 32'(1));
      chk("drop rdata", 32'(cpu_rdata), 32'(8'h4B));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("drop idle%0d", k),
             32'({busy, mem_en, cpu_ack, dma_ack}), 32'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
